// File: rtl/alarm_ringer_pkg.sv
// -----------------------------------------------------------------------------
// alarm_ringer_pkg
// Shared constants for the alarm ringer: FSM state encodings and the widths
// of the signals carried on the ringer interface.
// -----------------------------------------------------------------------------
package alarm_ringer_pkg;

    // FSM state encodings
    localparam logic [1:0] RING_IDLE   = 2'd0;
    localparam logic [1:0] RING_RING   = 2'd1;
    localparam logic [1:0] RING_SNOOZE = 2'd2;

    // Width of the seconds value coming from the clock block (0..59)
    localparam int SEC_W = 6;

    // Width of the snooze-used counter; MAX_SNOOZE must not exceed 3
    localparam int SNOOZE_CNT_W = 2;

    // Decode a state to a printable tag (simulation-friendly helper)
    function automatic string state_name(input logic [1:0] s);
        case (s)
            RING_IDLE:   return "IDLE";
            RING_RING:   return "RING";
            RING_SNOOZE: return "SNOOZE";
            default:     return "ILLEGAL";
        endcase
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// -----------------------------------------------------------------------------
// alarm_ringer_if
// Bundles the ringer's inputs (from Alarm, Clock and the user buttons) and its
// outputs (buzzer/LED drives plus a state debug view).
//
// Signalling: there is no valid/ready handshake on this interface. alarm_in,
// stop and snooze are levels whose rising edges are events; any change of
// sec_in is one seconds tick. All outputs are registered in the ringer and
// change only on clk edges.
//
//   master : drives alarm_in, sec_in, stop, snooze; observes the outputs
//   slave  : the ringer itself
// -----------------------------------------------------------------------------
interface alarm_ringer_if;
    import alarm_ringer_pkg::*;

    logic                    alarm_in;
    logic [SEC_W-1:0]        sec_in;
    logic                    stop;
    logic                    snooze;
    logic                    buzzer;
    logic                    ringing;
    logic                    snoozed;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt;
    logic [1:0]              state_dbg;

    modport master (
        output alarm_in, sec_in, stop, snooze,
        input  buzzer, ringing, snoozed, snooze_cnt, state_dbg
    );

    modport slave (
        input  alarm_in, sec_in, stop, snooze,
        output buzzer, ringing, snoozed, snooze_cnt, state_dbg
    );

endinterface

// File: rtl/alarm_ringer_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Single-bit rising-edge detector. The previous-value register loads
// RESET_VAL in reset so a level already high at reset release can be made
// to not count as an edge.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   in    : level input
//   rise  : high for the cycle where in=1 and the previous sample was 0
// -----------------------------------------------------------------------------
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
// Turns Alarm's match output into a beeping buzzer. Supports user stop,
// a bounded number of snoozes per alarm event and auto-silence after
// RING_SECS seconds. The seconds base is any change of Clock's seconds value.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : alarm_ringer_if.slave
//           in : alarm_in, sec_in, stop, snooze
//           out: buzzer, ringing, snoozed, snooze_cnt (registered),
//                state_dbg (current FSM state)
// -----------------------------------------------------------------------------
module alarm_ringer
    import alarm_ringer_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int BEEP_HALF   = 2
) (
    input  logic          clk,
    input  logic          reset,
    alarm_ringer_if.slave bus
);

    localparam int RW = $clog2(RING_SECS) + 1;
    localparam int SW = $clog2(SNOOZE_SECS) + 1;
    localparam int BW = $clog2(2 * BEEP_HALF) + 1;

    localparam logic [RW-1:0]           RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0]           SNZ_LOAD  = SW'(SNOOZE_SECS);
    localparam logic [BW-1:0]           BEEP_LAST = BW'(2 * BEEP_HALF - 1);
    localparam logic [BW-1:0]           BEEP_HI   = BW'(BEEP_HALF);
    localparam logic [SNOOZE_CNT_W-1:0] SNZ_MAX   = SNOOZE_CNT_W'(MAX_SNOOZE);

    // ---------------------------------------------------------------- edges
    logic alarm_rise;
    logic stop_rise;
    logic snooze_rise;

    // alarm_prev resets to 1 so an alarm held high through reset is not
    // mistaken for a fresh alarm event.
    rise_detect #(.RESET_VAL(1'b1)) u_alarm_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.alarm_in),
        .rise  (alarm_rise)
    );

    rise_detect #(.RESET_VAL(1'b0)) u_stop_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.stop),
        .rise  (stop_rise)
    );

    rise_detect #(.RESET_VAL(1'b0)) u_snooze_rise (
        .clk   (clk),
        .reset (reset),
        .in    (bus.snooze),
        .rise  (snooze_rise)
    );

    // --------------------------------------------------------- seconds tick
    // sec_prev captures sec_in even during reset, so the first cycle after
    // reset never sees a spurious tick. Any change (including 59->0 or a
    // clock reset to 0) is exactly one tick.
    logic [SEC_W-1:0] sec_prev;
    logic             tick;

    always_ff @(posedge clk) begin
        sec_prev <= bus.sec_in;
    end

    assign tick = (bus.sec_in != sec_prev);

    // ------------------------------------------------------------ registers
    logic [1:0]              state,      state_n;
    logic [RW-1:0]           ring_cnt,   ring_cnt_n;
    logic [SW-1:0]           snz_cnt,    snz_cnt_n;
    logic [BW-1:0]           beep_cnt,   beep_cnt_n;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt, snooze_cnt_n;

    logic [BW-1:0] beep_adv;
    assign beep_adv = (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + 1'b1;

    // ----------------------------------------------------- next-state logic
    always_comb begin
        state_n      = state;
        ring_cnt_n   = ring_cnt;
        snz_cnt_n    = snz_cnt;
        beep_cnt_n   = beep_cnt;
        snooze_cnt_n = snooze_cnt;

        case (state)
            RING_IDLE: begin
                if (alarm_rise) begin
                    state_n    = RING_RING;
                    ring_cnt_n = '0;
                    beep_cnt_n = '0;
                end
            end

            RING_RING: begin
                // stop beats snooze beats timeout; a refused snooze does not
                // swallow a tick arriving in the same cycle.
                if (stop_rise) begin
                    state_n      = RING_IDLE;
                    snooze_cnt_n = '0;
                end else if (snooze_rise && (snooze_cnt < SNZ_MAX)) begin
                    state_n      = RING_SNOOZE;
                    snz_cnt_n    = SNZ_LOAD;
                    snooze_cnt_n = snooze_cnt + 1'b1;
                end else if (tick && (ring_cnt == RING_LAST)) begin
                    state_n      = RING_IDLE;
                    snooze_cnt_n = '0;
                end else begin
                    beep_cnt_n = beep_adv;
                    if (tick) begin
                        ring_cnt_n = ring_cnt + 1'b1;
                    end
                end
            end

            RING_SNOOZE: begin
                if (stop_rise) begin
                    state_n      = RING_IDLE;
                    snooze_cnt_n = '0;
                end else if (tick) begin
                    if (snz_cnt == SW'(1)) begin
                        state_n    = RING_RING;
                        ring_cnt_n = '0;
                        beep_cnt_n = '0;
                    end else begin
                        snz_cnt_n = snz_cnt - 1'b1;
                    end
                end
            end

            default: begin
                state_n      = RING_IDLE;
                snooze_cnt_n = '0;
            end
        endcase
    end

    // ------------------------------------------------- state and outputs
    // Outputs are decoded from the next state so they change on the same edge
    // as the state; the buzzer is high on the very edge that enters RING.
    logic buzzer_q;
    logic ringing_q;
    logic snoozed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RING_IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            beep_cnt   <= '0;
            snooze_cnt <= '0;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            state      <= state_n;
            ring_cnt   <= ring_cnt_n;
            snz_cnt    <= snz_cnt_n;
            beep_cnt   <= beep_cnt_n;
            snooze_cnt <= snooze_cnt_n;
            buzzer_q   <= (state_n == RING_RING) && (beep_cnt_n < BEEP_HI);
            ringing_q  <= (state_n == RING_RING);
            snoozed_q  <= (state_n == RING_SNOOZE);
        end
    end

    assign bus.buzzer     = buzzer_q;
    assign bus.ringing    = ringing_q;
    assign bus.snoozed    = snoozed_q;
    assign bus.snooze_cnt = snooze_cnt;
    assign bus.state_dbg  = state;

endmodule
